sr_control_mc: RTL and testbench

- Multi-cycle successor of the single-cycle schoolRISCV control decoder.
- Sequences each instruction through fetch/decode/execute/memory/writeback states using ready handshakes to instruction and data memory.
- Adds LW/SW, the full RV32I branch set (parametrised), a sticky illegal-instruction trap, a data-memory timeout and a retired-instruction counter.
- Sits between the instruction register / decode fields and the multi-cycle datapath (PC, IR, ALU, register file, memory ports).

---
 rtl/sr_cpu_pkg.sv | 77 +++++++
 rtl/sr_decode_class.sv | 69 ++++++
 rtl/sr_control_mc.sv | 181 ++++++++++++++++++
 tb/tb_sr_control_mc.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_cpu_pkg.sv
// Shared definitions for the multi-cycle schoolRISCV control path.
// Opcode/funct fields, ALU encodings, mux selects and FSM state types.
package sr_cpu_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_OR   = 3'd1;
    localparam logic [2:0] ALU_SRL  = 3'd2;
    localparam logic [2:0] ALU_SLTU = 3'd3;
    localparam logic [2:0] ALU_SUB  = 3'd4;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JAL    = 2'd2
    } pc_src_t;

    typedef enum logic [1:0] {
        WD_ALU = 2'd0,
        WD_IMM = 2'd1,
        WD_MEM = 2'd2,
        WD_PC4 = 2'd3
    } wd_src_t;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        C_NONE, C_ALU_R, C_ADDI, C_LUI, C_BRANCH, C_JAL, C_LW, C_SW
    } instr_class_t;

    typedef enum logic [2:0] {
        BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU
    } br_cond_t;

    function automatic logic branchTaken(input br_cond_t cond,
                                         input logic zero,
                                         input logic lt,
                                         input logic ltu);
        logic taken;
        taken = 1'b0;
        unique case (cond)
            BR_EQ:   taken = zero;
            BR_NE:   taken = !zero;
            BR_LT:   taken = lt;
            BR_GE:   taken = !lt;
            BR_LTU:  taken = ltu;
            BR_GEU:  taken = !ltu;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/sr_decode_class.sv
// Combinational instruction classifier: {funct7, funct3, opcode} to
// instruction class, branch condition, ALU operation and illegal flag.
module sr_decode_class
    import sr_cpu_pkg::*;
#(
    parameter int ALU_W      = 3,
    parameter bit EXT_BRANCH = 1'b1
) (
    input  logic [6:0]       cmdOp,
    input  logic [2:0]       cmdF3,
    input  logic [6:0]       cmdF7,
    output instr_class_t     cls,
    output br_cond_t         cond,
    output logic [ALU_W-1:0] aluCtrl,
    output logic             illegal
);

    // Classify the current instruction word
    always_comb begin
        cls     = C_NONE;
        cond    = BR_EQ;
        aluCtrl = ALU_W'(ALU_ADD);
        unique case (cmdOp)
            OP_R: begin
                unique case ({cmdF7, cmdF3})
                    {F7_BASE, F3_ADD}:  cls = C_ALU_R;
                    {F7_ALT,  F3_ADD}: begin
                        cls     = C_ALU_R;
                        aluCtrl = ALU_W'(ALU_SUB);
                    end
                    {F7_BASE, F3_OR}: begin
                        cls     = C_ALU_R;
                        aluCtrl = ALU_W'(ALU_OR);
                    end
                    {F7_BASE, F3_SRL}: begin
                        cls     = C_ALU_R;
                        aluCtrl = ALU_W'(ALU_SRL);
                    end
                    {F7_BASE, F3_SLTU}: begin
                        cls     = C_ALU_R;
                        aluCtrl = ALU_W'(ALU_SLTU);
                    end
                    default: cls = C_NONE;
                endcase
            end
            OP_IMM:   if (cmdF3 == F3_ADD) cls = C_ADDI;
            OP_LUI:   cls = C_LUI;
            OP_JAL:   cls = C_JAL;
            OP_LOAD:  if (cmdF3 == F3_WORD) cls = C_LW;
            OP_STORE: if (cmdF3 == F3_WORD) cls = C_SW;
            OP_BRANCH: begin
                aluCtrl = ALU_W'(ALU_SUB);
                unique case (cmdF3)
                    F3_BEQ: begin cls = C_BRANCH; cond = BR_EQ; end
                    F3_BNE: begin cls = C_BRANCH; cond = BR_NE; end
                    F3_BLT:  if (EXT_BRANCH) begin cls = C_BRANCH; cond = BR_LT;  end
                    F3_BGE:  if (EXT_BRANCH) begin cls = C_BRANCH; cond = BR_GE;  end
                    F3_BLTU: if (EXT_BRANCH) begin cls = C_BRANCH; cond = BR_LTU; end
                    F3_BGEU: if (EXT_BRANCH) begin cls = C_BRANCH; cond = BR_GEU; end
                    default: cls = C_NONE;
                endcase
            end
            default: cls = C_NONE;
        endcase
    end

    assign illegal = (cls == C_NONE);

endmodule

// File: rtl/sr_control_mc.sv
// Multi-cycle schoolRISCV control FSM with memory handshakes,
// sticky illegal trap, data-memory timeout and retired-instruction count.
module sr_control_mc
    import sr_cpu_pkg::*;
#(
    parameter int ALU_W       = 3,
    parameter bit EXT_BRANCH  = 1'b1,
    parameter int MEM_TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       cmdOp,
    input  logic [2:0]       cmdF3,
    input  logic [6:0]       cmdF7,
    input  logic             aluZero,
    input  logic             aluLt,
    input  logic             aluLtu,
    input  logic             imemReady,
    input  logic             dmemReady,
    output logic             imemReq,
    output logic             irWrite,
    output logic             pcWrite,
    output logic [1:0]       pcSrc,
    output logic             regWrite,
    output logic             aluSrc,
    output logic [1:0]       wdSrc,
    output logic             dmemReq,
    output logic             dmemWe,
    output logic [ALU_W-1:0] aluControl,
    output logic             illegal,
    output logic [31:0]      instret
);

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT =
        CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t           state;
    state_t           stateNext;
    instr_class_t     clsQ;
    br_cond_t         condQ;
    logic [ALU_W-1:0] aluQ;
    instr_class_t     decCls;
    br_cond_t         decCond;
    logic [ALU_W-1:0] decAlu;
    logic             decIllegal;
    logic [CNT_W-1:0] memCnt;
    logic             memExpired;

    sr_decode_class #(
        .ALU_W      (ALU_W),
        .EXT_BRANCH (EXT_BRANCH)
    ) uDecode (
        .cmdOp   (cmdOp),
        .cmdF3   (cmdF3),
        .cmdF7   (cmdF7),
        .cls     (decCls),
        .cond    (decCond),
        .aluCtrl (decAlu),
        .illegal (decIllegal)
    );

    assign memExpired = (MEM_TIMEOUT != 0) && (memCnt == CNT_LIMIT);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= stateNext;
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        unique case (state)
            S_IDLE:   stateNext = S_FETCH;
            S_FETCH:  if (imemReady) stateNext = S_DECODE;
            S_DECODE: stateNext = decIllegal ? S_TRAP : S_EXEC;
            S_EXEC:   stateNext = (clsQ == C_LW || clsQ == C_SW) ? S_MEM : S_FETCH;
            S_MEM: begin
                if (dmemReady)       stateNext = (clsQ == C_LW) ? S_WB : S_FETCH;
                else if (memExpired) stateNext = S_TRAP;
            end
            S_WB:     stateNext = S_FETCH;
            S_TRAP:   stateNext = S_TRAP;
            default:  stateNext = S_IDLE;
        endcase
    end

    // Moore outputs; only irWrite, the S_MEM retire and the branch pick use inputs
    always_comb begin
        imemReq    = 1'b0;
        irWrite    = 1'b0;
        pcWrite    = 1'b0;
        pcSrc      = PC_PLUS4;
        regWrite   = 1'b0;
        aluSrc     = 1'b0;
        wdSrc      = WD_ALU;
        dmemReq    = 1'b0;
        dmemWe     = 1'b0;
        aluControl = ALU_W'(ALU_ADD);
        illegal    = 1'b0;
        unique case (state)
            S_FETCH: begin
                imemReq = 1'b1;
                irWrite = imemReady;
            end
            S_EXEC: begin
                aluControl = aluQ;
                unique case (clsQ)
                    C_ALU_R: begin
                        regWrite = 1'b1;
                        pcWrite  = 1'b1;
                    end
                    C_ADDI: begin
                        regWrite = 1'b1;
                        aluSrc   = 1'b1;
                        pcWrite  = 1'b1;
                    end
                    C_LUI: begin
                        regWrite = 1'b1;
                        wdSrc    = WD_IMM;
                        pcWrite  = 1'b1;
                    end
                    C_BRANCH: begin
                        pcWrite = 1'b1;
                        pcSrc   = branchTaken(condQ, aluZero, aluLt, aluLtu)
                                  ? PC_BRANCH : PC_PLUS4;
                    end
                    C_JAL: begin
                        regWrite = 1'b1;
                        wdSrc    = WD_PC4;
                        pcWrite  = 1'b1;
                        pcSrc    = PC_JAL;
                    end
                    C_LW, C_SW: aluSrc = 1'b1;
                    default: ;
                endcase
            end
            S_MEM: begin
                aluControl = aluQ;
                dmemReq    = 1'b1;
                dmemWe     = (clsQ == C_SW);
                pcWrite    = dmemReady && (clsQ == C_SW);
            end
            S_WB: begin
                regWrite = 1'b1;
                wdSrc    = WD_MEM;
                pcWrite  = 1'b1;
            end
            S_TRAP:  illegal = 1'b1;
            default: ;
        endcase
    end

    // Hold the decoded class for the rest of the instruction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clsQ  <= C_NONE;
            condQ <= BR_EQ;
            aluQ  <= ALU_W'(ALU_ADD);
        end else if (state == S_DECODE) begin
            clsQ  <= decCls;
            condQ <= decCond;
            aluQ  <= decAlu;
        end
    end

    // Count data-memory wait cycles; cleared whenever S_MEM is left
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                      memCnt <= '0;
        else if (state == S_MEM && stateNext == S_MEM) memCnt <= memCnt + 1'b1;
        else                                          memCnt <= '0;
    end

    // Retired-instruction counter, one per PC update
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          instret <= '0;
        else if (pcWrite) instret <= instret + 32'd1;
    end

endmodule

// File: tb/tb_sr_control_mc.sv
// Directed bench for sr_control_mc: a vector table for single-instruction
// flows plus hand sequences for memory waits, timeout, reset and wrap.
module tb_sr_control_mc;

    localparam logic [6:0] OPR   = 7'b0110011;
    localparam logic [6:0] OPI   = 7'b0010011;
    localparam logic [6:0] OPLUI = 7'b0110111;
    localparam logic [6:0] OPBR  = 7'b1100011;
    localparam logic [6:0] OPJAL = 7'b1101111;
    localparam logic [6:0] OPLD  = 7'b0000011;
    localparam logic [6:0] OPST  = 7'b0100011;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [6:0] cmdOp = '0;
    logic [2:0] cmdF3 = '0;
    logic [6:0] cmdF7 = '0;
    logic aluZero = 1'b0, aluLt = 1'b0, aluLtu = 1'b0;
    logic imemReady = 1'b0, dmemReady = 1'b0;

    logic imemReq, irWrite, pcWrite, regWrite, aluSrc, dmemReq, dmemWe, illegal;
    logic [1:0] pcSrc, wdSrc;
    logic [2:0] aluControl;
    logic [31:0] instret;

    logic imemReqB, irWriteB, pcWriteB, regWriteB, aluSrcB, dmemReqB, dmemWeB, illegalB;
    logic [1:0] pcSrcB, wdSrcB;
    logic [2:0] aluControlB;
    logic [31:0] instretB;

    int nCmp = 0;
    int nBad = 0;

    always #5 clk = ~clk;

    sr_control_mc #(.ALU_W(3), .EXT_BRANCH(1'b1), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .cmdOp(cmdOp), .cmdF3(cmdF3), .cmdF7(cmdF7),
        .aluZero(aluZero), .aluLt(aluLt), .aluLtu(aluLtu),
        .imemReady(imemReady), .dmemReady(dmemReady),
        .imemReq(imemReq), .irWrite(irWrite), .pcWrite(pcWrite), .pcSrc(pcSrc),
        .regWrite(regWrite), .aluSrc(aluSrc), .wdSrc(wdSrc),
        .dmemReq(dmemReq), .dmemWe(dmemWe), .aluControl(aluControl),
        .illegal(illegal), .instret(instret)
    );

    sr_control_mc #(.ALU_W(3), .EXT_BRANCH(1'b0), .MEM_TIMEOUT(0)) dutNoExt (
        .clk(clk), .rst(rst), .cmdOp(cmdOp), .cmdF3(cmdF3), .cmdF7(cmdF7),
        .aluZero(aluZero), .aluLt(aluLt), .aluLtu(aluLtu),
        .imemReady(imemReady), .dmemReady(dmemReady),
        .imemReq(imemReqB), .irWrite(irWriteB), .pcWrite(pcWriteB), .pcSrc(pcSrcB),
        .regWrite(regWriteB), .aluSrc(aluSrcB), .wdSrc(wdSrcB),
        .dmemReq(dmemReqB), .dmemWe(dmemWeB), .aluControl(aluControlB),
        .illegal(illegalB), .instret(instretB)
    );

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [2:0] flags;
        logic       trap;
        logic       rw;
        logic       aSrc;
        logic [1:0] wd;
        logic [1:0] pc;
        logic [2:0] alu;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string n, logic [6:0] op, logic [2:0] f3,
                                logic [6:0] f7, logic [2:0] fl, logic tr,
                                logic rw, logic aSrc, logic [1:0] wd,
                                logic [1:0] pc, logic [2:0] alu);
        vec_t v;
        v.name = n; v.op = op; v.f3 = f3; v.f7 = f7; v.flags = fl;
        v.trap = tr; v.rw = rw; v.aSrc = aSrc; v.wd = wd; v.pc = pc; v.alu = alu;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setCmd(input logic [6:0] op, input logic [2:0] f3,
                          input logic [6:0] f7);
        cmdOp = op; cmdF3 = f3; cmdF7 = f7;
    endtask

    task automatic doReset();
        rst = 1'b1;
        imemReady = 1'b1;
        dmemReady = 1'b0;
        #1;
        check("rst.imemReq", imemReq, 0);
        check("rst.illegal", illegal, 0);
        check("rst.instret", instret, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic runVec(input vec_t v);
        doReset();
        setCmd(v.op, v.f3, v.f7);
        {aluZero, aluLt, aluLtu} = v.flags;
        step();
        check({v.name, ".irWrite"}, irWrite, 1);
        step();
        check({v.name, ".decPcWrite"}, pcWrite, 0);
        step();
        if (v.trap) begin
            check({v.name, ".illegal"}, illegal, 1);
            check({v.name, ".trapPcWrite"}, pcWrite, 0);
            check({v.name, ".trapRegWrite"}, regWrite, 0);
            step();
            check({v.name, ".sticky"}, {imemReq, illegal}, 2'b01);
        end else begin
            check({v.name, ".regWrite"}, regWrite, v.rw);
            check({v.name, ".aluSrc"}, aluSrc, v.aSrc);
            check({v.name, ".wdSrc"}, wdSrc, v.wd);
            check({v.name, ".pcSrc"}, pcSrc, v.pc);
            check({v.name, ".aluControl"}, aluControl, v.alu);
            check({v.name, ".pcWrite"}, pcWrite, 1);
            step();
            check({v.name, ".refetch"}, imemReq, 1);
            check({v.name, ".instret"}, instret, 1);
        end
    endtask

    initial begin
        vecs.push_back(mk("add",   OPR,   3'b000, 7'h00, 3'b000, 0, 1, 0, 2'd0, 2'd0, 3'd0));
        vecs.push_back(mk("sub",   OPR,   3'b000, 7'h20, 3'b000, 0, 1, 0, 2'd0, 2'd0, 3'd4));
        vecs.push_back(mk("or",    OPR,   3'b110, 7'h00, 3'b000, 0, 1, 0, 2'd0, 2'd0, 3'd1));
        vecs.push_back(mk("srl",   OPR,   3'b101, 7'h00, 3'b000, 0, 1, 0, 2'd0, 2'd0, 3'd2));
        vecs.push_back(mk("sltu",  OPR,   3'b011, 7'h00, 3'b000, 0, 1, 0, 2'd0, 2'd0, 3'd3));
        vecs.push_back(mk("addi",  OPI,   3'b000, 7'h20, 3'b000, 0, 1, 1, 2'd0, 2'd0, 3'd0));
        vecs.push_back(mk("lui",   OPLUI, 3'b101, 7'h55, 3'b000, 0, 1, 0, 2'd1, 2'd0, 3'd0));
        vecs.push_back(mk("jal",   OPJAL, 3'b011, 7'h7f, 3'b000, 0, 1, 0, 2'd3, 2'd2, 3'd0));
        vecs.push_back(mk("beqT",  OPBR,  3'b000, 7'h00, 3'b100, 0, 0, 0, 2'd0, 2'd1, 3'd4));
        vecs.push_back(mk("beqN",  OPBR,  3'b000, 7'h00, 3'b011, 0, 0, 0, 2'd0, 2'd0, 3'd4));
        vecs.push_back(mk("bneN",  OPBR,  3'b001, 7'h00, 3'b100, 0, 0, 0, 2'd0, 2'd0, 3'd4));
        vecs.push_back(mk("bneT",  OPBR,  3'b001, 7'h00, 3'b011, 0, 0, 0, 2'd0, 2'd1, 3'd4));
        vecs.push_back(mk("bltT",  OPBR,  3'b100, 7'h00, 3'b010, 0, 0, 0, 2'd0, 2'd1, 3'd4));
        vecs.push_back(mk("bltN",  OPBR,  3'b100, 7'h00, 3'b101, 0, 0, 0, 2'd0, 2'd0, 3'd4));
        vecs.push_back(mk("bgeT",  OPBR,  3'b101, 7'h00, 3'b101, 0, 0, 0, 2'd0, 2'd1, 3'd4));
        vecs.push_back(mk("bgeN",  OPBR,  3'b101, 7'h00, 3'b010, 0, 0, 0, 2'd0, 2'd0, 3'd4));
        vecs.push_back(mk("bltuT", OPBR,  3'b110, 7'h00, 3'b001, 0, 0, 0, 2'd0, 2'd1, 3'd4));
        vecs.push_back(mk("bltuN", OPBR,  3'b110, 7'h00, 3'b010, 0, 0, 0, 2'd0, 2'd0, 3'd4));
        vecs.push_back(mk("bgeuN", OPBR,  3'b111, 7'h00, 3'b001, 0, 0, 0, 2'd0, 2'd0, 3'd4));
        vecs.push_back(mk("bgeuT", OPBR,  3'b111, 7'h00, 3'b110, 0, 0, 0, 2'd0, 2'd1, 3'd4));
        vecs.push_back(mk("illF7", OPR,   3'b110, 7'h20, 3'b000, 1, 0, 0, 2'd0, 2'd0, 3'd0));
        vecs.push_back(mk("sra",   OPR,   3'b101, 7'h20, 3'b000, 1, 0, 0, 2'd0, 2'd0, 3'd0));
        vecs.push_back(mk("br010", OPBR,  3'b010, 7'h00, 3'b000, 1, 0, 0, 2'd0, 2'd0, 3'd0));
        vecs.push_back(mk("lb",    OPLD,  3'b000, 7'h00, 3'b000, 1, 0, 0, 2'd0, 2'd0, 3'd0));
        vecs.push_back(mk("sb",    OPST,  3'b000, 7'h00, 3'b000, 1, 0, 0, 2'd0, 2'd0, 3'd0));
        vecs.push_back(mk("badOp", 7'h7f, 3'b000, 7'h00, 3'b000, 1, 0, 0, 2'd0, 2'd0, 3'd0));

        rst = 1'b1;
        #1;
        check("rst.pcSrc", pcSrc, 0);
        check("rst.wdSrc", wdSrc, 0);
        check("rst.aluControl", aluControl, 0);
        check("rst.enables", {irWrite, pcWrite, regWrite, aluSrc, dmemReq, dmemWe}, 0);

        foreach (vecs[i]) runVec(vecs[i]);

        // LW with ready on the 4th wait cycle: ready at the timeout limit wins
        doReset();
        setCmd(OPLD, 3'b010, 7'h00);
        step(); step(); step();
        check("lw.exec", {aluSrc, aluControl, pcWrite, dmemReq}, {1'b1, 3'd0, 2'b00});
        for (int k = 0; k < 3; k++) begin
            step();
            check("lw.wait", {dmemReq, dmemWe, regWrite, pcWrite}, 4'b1000);
        end
        step();
        dmemReady = 1'b1;
        #1;
        check("lw.ready", {dmemReq, dmemWe, pcWrite, illegal}, 4'b1000);
        step();
        dmemReady = 1'b0;
        check("lw.wb", {regWrite, wdSrc, pcWrite, pcSrc}, {1'b1, 2'd2, 1'b1, 2'd0});
        step();
        check("lw.refetch", imemReq, 1);
        check("lw.instret", instret, 1);

        // SW with no ready: MEM_TIMEOUT=4 traps, MEM_TIMEOUT=0 keeps waiting
        doReset();
        setCmd(OPST, 3'b010, 7'h00);
        step(); step(); step();
        check("sw.exec", {aluSrc, dmemReq, pcWrite}, 3'b100);
        for (int k = 0; k < 4; k++) begin
            step();
            check("sw.wait", {dmemReq, dmemWe, pcWrite, regWrite, illegal}, 5'b11000);
        end
        step();
        check("sw.trap", {illegal, dmemReq, pcWrite}, 3'b100);
        check("sw.noTimeoutWaits", dmemReqB, 1);
        for (int k = 0; k < 3; k++) begin
            step();
            check("sw.sticky", {illegal, imemReq, pcWrite, regWrite}, 4'b1000);
        end
        dmemReady = 1'b1;
        #1;
        check("sw.doneB", {pcWriteB, pcSrcB, dmemWeB, regWriteB}, {1'b1, 2'd0, 2'b10});
        check("sw.trapIgnoresReady", {illegal, pcWrite}, 2'b10);
        step();
        dmemReady = 1'b0;
        check("sw.refetchB", imemReqB, 1);
        check("sw.instretB", instretB, 1);
        check("sw.instretTrap", instret, 0);

        // Base-branch build: BLT is illegal there, BEQ still works
        doReset();
        setCmd(OPBR, 3'b100, 7'h00);
        {aluZero, aluLt, aluLtu} = 3'b010;
        step(); step(); step();
        check("noext.blt", {illegalB, pcWriteB}, 2'b10);
        check("ext.blt", {pcWrite, pcSrc}, {1'b1, 2'd1});
        for (int k = 0; k < 4; k++) begin
            step();
            check("noext.sticky", {illegalB, imemReqB, pcWriteB}, 3'b100);
        end
        doReset();
        check("noext.cleared", illegalB, 0);
        setCmd(OPBR, 3'b000, 7'h00);
        {aluZero, aluLt, aluLtu} = 3'b100;
        step(); step(); step();
        check("noext.beq", {pcWriteB, pcSrcB, aluControlB}, {1'b1, 2'd1, 3'd4});

        // Reset asserted in the middle of an S_MEM wait
        doReset();
        setCmd(OPR, 3'b000, 7'h00);
        step(); step(); step(); step();
        check("mid.instret1", instret, 1);
        setCmd(OPLD, 3'b010, 7'h00);
        step(); step(); step();
        check("mid.inMem", dmemReq, 1);
        #2;
        rst = 1'b1;
        #1;
        check("mid.async", {dmemReq, imemReq, regWrite, pcWrite}, 4'b0000);
        check("mid.instret0", instret, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("mid.idle", imemReq, 0);
        step();
        check("mid.restart", {imemReq, irWrite}, 2'b11);

        // instret wraps from all-ones to zero
        doReset();
        setCmd(OPR, 3'b000, 7'h00);
        step(); step();
        force dut.instret = 32'hFFFF_FFFF;
        #1;
        release dut.instret;
        #1;
        step();
        check("wrap.pcWrite", pcWrite, 1);
        step();
        check("wrap.instret", instret, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
